// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver with its own prescaler; it resyncs on every start edge
// and samples each bit at mid-bit, then reports a good byte or a framing error.
module uart_rx_oversampled #(
    parameter int DIVISOR    = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 fast_clock,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_error,
    output logic                 busy
);
    localparam int PW = $clog2(DIVISOR);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIVISOR - 1);
    localparam logic [OW-1:0] HALF = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] LAST = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t               state, state_n;
    logic                 rx_m, rx_s, tick, valid_n, ferr_n;
    logic [PW-1:0]        pre, pre_n;
    logic [OW-1:0]        phase, phase_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n, data_n;

    assign tick = pre == PRE_LAST;
    assign busy = state != IDLE;

    always_ff @(posedge fast_clock or posedge rst) begin
        if (rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            pre         <= '0;
            phase       <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_m        <= rx_serial;
            rx_s        <= rx_m;
            state       <= state_n;
            pre         <= pre_n;
            phase       <= phase_n;
            bit_cnt     <= bit_n;
            shift       <= shift_n;
            rx_data     <= data_n;
            rx_valid    <= valid_n;
            frame_error <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        pre_n   = tick ? '0 : pre + 1'b1;
        phase_n = phase;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: if (!rx_s) begin
                // restart the prescaler so tick phase is locked to the start edge
                state_n = START;
                pre_n   = '0;
                phase_n = '0;
                bit_n   = '0;
            end
            START: if (tick) begin
                if (phase == HALF) begin
                    state_n = rx_s ? IDLE : DATA;
                    phase_n = '0;
                end else phase_n = phase + 1'b1;
            end
            DATA: if (tick) begin
                if (phase == LAST) begin
                    shift_n = DATA_BITS'({rx_s, shift} >> 1);
                    phase_n = '0;
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) state_n = STOP;
                end else phase_n = phase + 1'b1;
            end
            STOP: if (tick) begin
                if (phase == LAST) begin
                    state_n = rx_s ? IDLE : WAIT_IDLE;
                    data_n  = rx_s ? shift : rx_data;
                    valid_n = rx_s;
                    ferr_n  = !rx_s;
                end else phase_n = phase + 1'b1;
            end
            WAIT_IDLE: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: drives serial frames at chosen bit times and checks received bytes, strobes,
// latency and busy against an expected-byte queue built from the frames sent.
module tb_uart_rx_oversampled;
    localparam int D = 4, OS = 16, DB = 8, BT = D * OS;
    localparam int LAT = (19 * D * OS) / 2 + 3;

    logic          fast_clock = 1'b0, rst = 1'b1, rx_serial = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_error, busy;
    int            cyc = 0, n_chk = 0, n_fail = 0, ferr_cnt = 0;
    logic          prev_valid = 1'b0, prev_ferr = 1'b0;
    logic [7:0]    got_q[$], exp_q[$];
    int            got_cyc[$];

    uart_rx_oversampled #(.DIVISOR(D), .OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .fast_clock(fast_clock), .rst(rst), .rx_serial(rx_serial), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 fast_clock = ~fast_clock;
    always @(posedge fast_clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge fast_clock);
    endtask

    // one frame: start bit, LSB-first data, one stop bit; line is left at the stop level
    task automatic tx(input logic [7:0] b, input logic stop, input int bt);
        rx_serial = 1'b0;
        wait_cyc(bt);
        for (int i = 0; i < DB; i++) begin
            rx_serial = b[i];
            wait_cyc(bt);
        end
        rx_serial = stop;
        wait_cyc(bt);
        if (stop) exp_q.push_back(b);
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    always @(negedge fast_clock) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            got_cyc.push_back(cyc);
            check("valid_width", prev_valid, 0);
        end
        if (frame_error) begin
            ferr_cnt++;
            check("ferr_width", prev_ferr, 0);
        end
        if (rx_valid || frame_error) check("valid_ferr_excl", rx_valid & frame_error, 0);
        prev_valid = rx_valid;
        prev_ferr  = frame_error;
    end

    initial begin
        int s, lat, f0, exp_ferr;
        logic [7:0] prior;
        logic [7:0] b;
        logic       stop;
        int         bt;
        wait_cyc(4);
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_ferr", frame_error, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        wait_cyc(10);

        rx_serial = 1'b0;
        wait_cyc(300);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        rx_serial = 1'b1;
        wait_cyc(3);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        wait_cyc(1000);
        check("mid_no_ferr", ferr_cnt, 0);
        tx(8'h3C, 1'b1, BT);
        wait_cyc(BT);
        drain("after_rst");

        s = cyc;
        fork
            tx(8'hA5, 1'b1, BT);
            begin
                for (int k = 0; k < 700 && !rx_valid; k++) @(negedge fast_clock);
                check("a5_valid_seen", rx_valid, 1);
                lat = cyc - s;
                check("a5_latency", (lat >= LAT - 1 && lat <= LAT + 1) ? LAT : lat, LAT);
                @(negedge fast_clock);
                check("a5_valid_one_cycle", rx_valid, 0);
                @(negedge fast_clock);
                check("a5_busy_drop", busy, 0);
            end
        join
        wait_cyc(BT);
        check("a5_rx_data", rx_data, 8'hA5);
        drain("single");

        tx(8'h00, 1'b1, BT);
        tx(8'hFF, 1'b1, BT);
        tx(8'h55, 1'b1, BT);
        wait_cyc(BT);
        check("b2b_pulses", got_cyc.size(), 3);
        if (got_cyc.size() == 3)
            for (int i = 1; i < 3; i++) begin
                lat = got_cyc[i] - got_cyc[i-1];
                check("b2b_spacing", (lat >= 10 * BT - 1 && lat <= 10 * BT + 1) ? 10 * BT : lat, 10 * BT);
            end
        drain("b2b");

        prior = rx_data;
        rx_serial = 1'b0;
        wait_cyc(20);
        rx_serial = 1'b1;
        wait_cyc(200);
        check("glitch_busy", busy, 0);
        check("glitch_data", rx_data, prior);
        drain("glitch");

        f0 = ferr_cnt;
        tx(8'h81, 1'b0, BT);
        wait_cyc(2000);
        check("break_busy", busy, 1);
        rx_serial = 1'b1;
        wait_cyc(4);
        check("break_busy_release", busy, 0);
        check("break_ferr_pulses", ferr_cnt - f0, 1);
        check("break_data_kept", rx_data, prior);
        drain("break");
        tx(8'h42, 1'b1, BT);
        wait_cyc(BT);
        drain("after_break");

        tx(8'h96, 1'b1, 61);
        wait_cyc(200);
        tx(8'h96, 1'b1, 67);
        wait_cyc(200);
        drain("tolerance");

        f0 = ferr_cnt;
        exp_ferr = 0;
        for (int n = 0; n < 10; n++) begin
            b    = 8'($urandom);
            stop = $urandom_range(0, 4) != 0;
            bt   = $urandom_range(62, 66);
            tx(b, stop, bt);
            if (!stop) begin
                exp_ferr++;
                rx_serial = 1'b1;
                wait_cyc(bt);
            end
            wait_cyc($urandom_range(0, 40));
        end
        rx_serial = 1'b1;
        wait_cyc(BT);
        check("rand_ferr", ferr_cnt - f0, exp_ferr);
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART receiver that converts the serial line into parallel bytes. Receive-side counterpart of the transmit path.
- Contains its own prescaler (fast_clock ÷ DIVISOR → oversample tick) and an OVERSAMPLE-per-bit phase counter.
- Resynchronises to every start bit and samples each bit at mid-bit.
- Sits between the raw rx pin and the byte consumer; outputs a one-cycle valid strobe per good frame.

Parameters:
- DIVISOR, 4: fast_clock cycles per oversample tick; legal values ≥2.
- OVERSAMPLE, 16: ticks per bit; even, ≥4.
- DATA_BITS, 8: data bits per frame; LSB first, no parity, 1 stop bit.

Ports:
- fast_clock  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_serial  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last correctly received byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- frame_error  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: while rst is high, all registers are cleared immediately.
  - state=IDLE; rx_data=0; rx_valid=0; frame_error=0; busy=0.
  - Synchroniser flops reset to 1 (line idle).
  - Asserting rst mid-frame aborts the frame with no strobe. Reception restarts only on a fresh falling edge after rst deasserts.
- Input synchroniser: two flops on rx_serial. All decisions use the second flop (rx_s). This gives 2 cycles of latency.
- Prescaler: counter runs 0..DIVISOR-1. tick is high for one cycle when count==DIVISOR-1. The counter is cleared on the IDLE→START transition so phase aligns to the start edge.
- Phase counter: counts ticks 0..OVERSAMPLE-1; cleared with the prescaler.
- Bit counter: counts 0..DATA_BITS-1.
- Counter widths are $clog2 of their respective ranges.
- IDLE: when rx_s==0, go to START. busy rises the next cycle.
- START: at the tick where phase==OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - If 1 (glitch): return to IDLE, no strobe.
  - If 0: clear phase, go to DATA.
- DATA: on the tick where phase==OVERSAMPLE-1 (one full bit later, i.e. mid-bit):
  - Shift rx_s into the shift register MSB; after DATA_BITS shifts the LSB-first byte is aligned.
  - Clear phase and increment the bit counter.
  - After bit DATA_BITS-1, go to STOP.
- STOP: on the tick where phase==OVERSAMPLE-1, sample rx_s.
  - If 1: rx_data←shift register; rx_valid=1 for exactly the next cycle; go to IDLE.
  - If 0: frame_error=1 for one cycle; rx_data unchanged; go to WAIT_IDLE.
- WAIT_IDLE (break/line-low recovery): stay until rx_s==1, then go to IDLE. busy stays high. This prevents a held-low line from producing repeated frames.
- Back-to-back frames: a start edge in the cycle after the STOP→IDLE transition must be accepted.
  - Stop-bit sampling is at mid-bit, so the line's second half of the stop bit is already idle-watched.
- rx_valid and frame_error are never high in the same cycle. Neither is asserted outside a STOP sample.
- Latency: rx_valid rises (9.5 × DIVISOR × OVERSAMPLE) + 3 cycles after the rx_serial falling edge, ±1 cycle.
  - For the defaults this is 611 ±1.
- No flow control: a new byte overwrites rx_data whether or not the consumer has read it.

Test Plan:
- Reset values: hold rst with rx_serial=1 → all outputs 0. Assert rst at 300 cycles into a frame → no rx_valid/frame_error; the next frame 0x3C is received correctly.
- Single frame, defaults (64 cycles/bit): send 0xA5 LSB first with stop=1 → rx_valid is one cycle wide at 611±1 cycles after the start edge; rx_data=0xA5; busy drops within 2 cycles.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap → three rx_valid pulses exactly 640±1 cycles apart, with the correct bytes in order.
- Glitch rejection: pull rx_serial low for 20 cycles (shorter than half a bit = 32) → returns to IDLE, no strobes, rx_data unchanged.
- Framing error/break: send 0x81 with stop=0, then hold low 2000 cycles, then idle → one frame_error pulse, no rx_valid, rx_data keeps its prior value; busy stays high until the line returns high; the next 0x42 is received OK.
- Baud tolerance: DIVISOR=4, transmitter bit time 61 and 67 cycles (±4.7%), byte 0x96 → received correctly with rx_valid in both cases.
